// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the single-clock FIFO family.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter
  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // Ceiling log2, used to size pointers from the entry count
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  // The fill level must represent 0..DEPTH inclusive, hence one extra bit
  function automatic int level_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for the FIFO.
// Registered read port for the classic mode, asynchronous read port for first-word-fall-through.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int FWFT  = MODE_REG,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is written on the clock edge; contents are left unreset on purpose
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT == MODE_FWFT) begin : g_async_read
      // The head word is visible without waiting for a clock
      assign rdata = mem[raddr];
    end else begin : g_sync_read
      // The output register only moves on an accepted read so the last word is held
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/fifo_sc_param.sv
// Parametrised single-clock FIFO between wavelet lift stages and the row/column buffers.
// Holds pointers, fill level, registered status flags and sticky error flags; storage is in fifo_ram.
module fifo_sc_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 16,
  parameter int FWFT     = MODE_REG,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          enw,
  input  logic [WIDTH-1:0]              datain,
  input  logic                          enr,
  output logic [WIDTH-1:0]              dataout,
  output logic                          empty,
  output logic                          full,
  output logic                          afull,
  output logic                          aempty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          ovf,
  output logic                          udf
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [LW-1:0]    level_nxt;
  logic [WIDTH-1:0] ram_rdata;

  // A write into a full FIFO is still fine when a read frees a slot in the same cycle
  assign wr_ok = enw & (~full | enr);
  assign rd_ok = enr & ~empty;

  // Next fill level; a flush wins over any traffic in the same cycle
  always_comb begin
    level_nxt = level;
    if (clr)                 level_nxt = '0;
    else if (wr_ok & ~rd_ok) level_nxt = level + LW'(1);
    else if (rd_ok & ~wr_ok) level_nxt = level - LW'(1);
  end

  // Pointers, level, status flags (derived from the post-edge level) and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      afull  <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (wr_ok)              wr_ptr <= wr_ptr + AW'(1);
        if (rd_ok)              rd_ptr <= rd_ptr + AW'(1);
        if (enw & full & ~enr)  ovf    <= 1'b1;
        if (enr & empty)        udf    <= 1'b1;
      end
      level  <= level_nxt;
      empty  <= (level_nxt == '0);
      full   <= (level_nxt == DEPTH_L);
      afull  <= (level_nxt >= AF_L);
      aempty <= (level_nxt <= AE_L);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FWFT  (FWFT),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok & ~clr),
    .waddr (wr_ptr),
    .wdata (datain),
    .re    (rd_ok & ~clr),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft_out
      logic [WIDTH-1:0] hold_q;

      // Remember whatever is currently shown so an empty FIFO keeps presenting the last word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= dataout;
      end

      assign dataout = empty ? hold_q : ram_rdata;
    end else begin : g_reg_out
      assign dataout = ram_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sc_param.sv
// Bench for fifo_sc_param: one registered-read and one FWFT instance driven in lock-step,
// both compared every cycle against a queue-based reference model.
module tb_fifo_sc_param;

  localparam int WIDTH = 9;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  localparam int AEL   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             enw = 1'b0;
  logic             enr = 1'b0;
  logic [WIDTH-1:0] datain = '0;

  logic [WIDTH-1:0] r_dataout, f_dataout;
  logic             r_empty, r_full, r_afull, r_aempty, r_ovf, r_udf;
  logic             f_empty, f_full, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0]       r_level, f_level;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               m_ovf, m_udf;
  logic [WIDTH-1:0] m_reg_out, m_fwft_last;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  fifo_sc_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut_reg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .enw(enw), .datain(datain), .enr(enr),
    .dataout(r_dataout), .empty(r_empty), .full(r_full), .afull(r_afull), .aempty(r_aempty),
    .level(r_level), .ovf(r_ovf), .udf(r_udf)
  );

  fifo_sc_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .enw(enw), .datain(datain), .enr(enr),
    .dataout(f_dataout), .empty(f_empty), .full(f_full), .afull(f_afull), .aempty(f_aempty),
    .level(f_level), .ovf(f_ovf), .udf(f_udf)
  );

  // Global time limit so a broken design can never hang the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    m_ovf       = 1'b0;
    m_udf       = 1'b0;
    m_reg_out   = '0;
    m_fwft_last = '0;
  endtask

  // Reference behaviour of one clock edge, expressed as queue operations
  task automatic modelStep(input bit w, input bit r, input bit c, input logic [WIDTH-1:0] d);
    int n;
    n = model_q.size();
    if (n > 0) m_fwft_last = model_q[0];
    if (c) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    if (w && n == DEPTH && !r) m_ovf = 1'b1;
    if (r && n == 0)           m_udf = 1'b1;
    if (r && n > 0)            m_reg_out = model_q.pop_front();
    if (w && (n < DEPTH || r)) model_q.push_back(d);
  endtask

  task automatic checkOne(input string tag, input logic [WIDTH-1:0] d, input logic e, input logic f,
                          input logic af, input logic ae, input logic [4:0] lv, input logic o,
                          input logic u, input logic [WIDTH-1:0] exp_d);
    int n;
    n = model_q.size();
    check({tag, " level"},   32'(lv), 32'(n));
    check({tag, " empty"},   32'(e),  32'(n == 0));
    check({tag, " full"},    32'(f),  32'(n == DEPTH));
    check({tag, " afull"},   32'(af), 32'(n >= AFL));
    check({tag, " aempty"},  32'(ae), 32'(n <= AEL));
    check({tag, " ovf"},     32'(o),  32'(m_ovf));
    check({tag, " udf"},     32'(u),  32'(m_udf));
    check({tag, " dataout"}, 32'(d),  32'(exp_d));
  endtask

  task automatic checkOutput(input string phase);
    logic [WIDTH-1:0] exp_fwft;
    exp_fwft = (model_q.size() > 0) ? model_q[0] : m_fwft_last;
    checkOne({phase, "/reg"}, r_dataout, r_empty, r_full, r_afull, r_aempty, r_level, r_ovf, r_udf,
             m_reg_out);
    checkOne({phase, "/fwft"}, f_dataout, f_empty, f_full, f_afull, f_aempty, f_level, f_ovf, f_udf,
             exp_fwft);
  endtask

  // Drive one cycle of inputs on the falling edge, advance the model on the rising edge, then compare
  task automatic applyStimulus(input bit w, input bit r, input bit c, input logic [WIDTH-1:0] d,
                               input string phase);
    @(negedge clk);
    enw    = w;
    enr    = r;
    clr    = c;
    datain = d;
    @(posedge clk);
    modelStep(w, r, c, d);
    #2;
    checkOutput(phase);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, '0, "idle");

    // Fill completely, then one write too many
    for (int i = 1; i <= 16; i++) applyStimulus(1, 0, 0, WIDTH'(i), "fill");
    applyStimulus(1, 0, 0, 9'h1FF, "overflow");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, '0, "drain");

    // Sustained read+write while full, across pointer wrap
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, WIDTH'(9'h100 + i), "refill");
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0, WIDTH'(9'h020 + i), "stream");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, '0, "flush_out");

    // Read of an empty FIFO together with a write
    applyStimulus(1, 1, 0, 9'h0AA, "underflow");
    applyStimulus(0, 0, 0, '0, "underflow_hold");
    applyStimulus(0, 1, 0, '0, "underflow_pop");
    applyStimulus(0, 0, 0, '0, "empty_hold");

    // Flush with a simultaneous write
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, WIDTH'(9'h040 + i), "prefill");
    applyStimulus(1, 0, 1, 9'h155, "clr");
    applyStimulus(0, 0, 0, '0, "after_clr");
    applyStimulus(1, 0, 0, 9'h0C3, "post_clr_write");
    applyStimulus(0, 1, 0, '0, "post_clr_read");

    // Random traffic with alternating write-heavy and read-heavy phases
    for (int i = 0; i < 400; i++) begin
      int bias;
      bit w, r, c;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 63) == 0);
      applyStimulus(w, r, c, WIDTH'($urandom), "random");
    end

    // Asynchronous reset between edges with data in flight
    applyStimulus(0, 0, 1, '0, "pre_reset_clr");
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, WIDTH'(9'h070 + i), "pre_reset_fill");
    applyStimulus(0, 1, 0, '0, "pre_reset_read");
    @(negedge clk);
    enw = 1'b0;
    enr = 1'b0;
    clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 9'h0E1, "post_reset_write");
    applyStimulus(0, 1, 0, '0, "post_reset_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sc_param.md
Name: fifo_sc_param

Overview:
Parametrised single-clock FIFO, next generation of the 9-bit fifo used between lifting-stage pipeline blocks.
- Width, depth and read mode (registered vs first-word-fall-through) are set by parameters.
- Adds fill level, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between wavelet lift stages and the row/column buffer controllers.

Parameters:
- WIDTH, 9, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- FWFT, 0, 0 = registered read (data one cycle after enr); 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, afull asserted when level >= AF_LEVEL
- AE_LEVEL, 2, aempty asserted when level <= AE_LEVEL

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: empties the FIFO and clears the error flags
- enw  in  1  write request
- datain  in  WIDTH  write data
- enr  in  1  read request (FWFT=1: pop/acknowledge)
- dataout  out  WIDTH  read data
- empty  out  1  no entries
- full  out  1  DEPTH entries
- afull  out  1  almost full
- aempty  out  1  almost empty
- level  out  clog2(DEPTH)+1  current entry count, 0..DEPTH
- ovf  out  1  sticky: write attempted while full and not simultaneously read
- udf  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, level=0, empty=1, aempty=1, full=0, afull=0, ovf=0, udf=0, dataout=0. Memory contents are don't-care.
- Accept rules:
  - wr_ok = enw & (!full | enr)
  - rd_ok = enr & !empty
- Pointers are clog2(DEPTH) bits and wrap naturally at DEPTH.
- Level update: level += wr_ok - rd_ok.
- Flags: empty/full/afull/aempty are registered and describe the state after the edge; they are never combinational from enr/enw.
- Full with enw & enr: both accepted, level unchanged, ovf not set.
- Empty with enw & enr: write accepted, read rejected, udf set. FWFT=0: dataout holds.
- enw & full & !enr: write dropped, ovf set, contents unchanged.
- Registered mode (FWFT=0):
  - rd_ok at edge N puts the head word on dataout after edge N; 1-cycle latency.
  - dataout holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - dataout shows the head word whenever !empty.
  - A word written into an empty FIFO appears on dataout one cycle after the write edge, coincident with empty falling.
  - rd_ok advances dataout to the next word in the same edge.
  - When empty, dataout holds the last value.
- clr (synchronous): has priority over enr/enw in that cycle. Result is level=0, empty=1, ovf=udf=0. dataout holds in both modes.
- Reset asserted mid-operation: immediate return to the reset state; in-flight data is lost.
- Throughput: one write and one read per cycle sustained. No bubble at wrap-around.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function
  - FWFT mode constants (MODE_REG=0, MODE_FWFT=1)
  - level-width helper
- Sub-module fifo_ram:
  - simple dual-port array, WIDTH x DEPTH
  - synchronous write
  - synchronous read port with read enable (FWFT=0) or asynchronous read port (FWFT=1), selected by parameter
- Pointer/level/flag logic stays in fifo_sc_param.

Test Plan:
- Reset then idle (WIDTH=9, DEPTH=16, FWFT=0) -> empty=1, aempty=1, level=0, dataout=0, ovf=udf=0.
- Write 0x001..0x010 (16 words), then a 17th write 0x1FF without read -> full=1 and afull=1 (from level 14), level=16, ovf=1. Then 16 reads return 0x001..0x010 in order, each one cycle after its enr; empty=1 at the end.
- Fill to 16, then 40 cycles of simultaneous enw/enr with an incrementing pattern -> level stays 16, no ovf, output order preserved across pointer wrap.
- enr on an empty FIFO together with enw of 0x0AA -> udf=1, level=1. With FWFT=1, dataout=0x0AA the next cycle with no enr.
- Fill to 5, pulse clr with enw=1 -> level=0, empty=1, ovf/udf cleared, written word discarded.
- Fill to 7, assert rst_n=0 asynchronously between edges -> all outputs return to reset values before the next clock edge.
